// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad entry / seven-segment display blocks.
// Holds the debounce FSM state encoding and the active-low segment patterns
// ({g,f,e,d,c,b,a}) for hex digits 0-F plus the blank and anode-off values.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } kp_state_e;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

endpackage

// File: rtl/hex_to_seg7.sv
// Purpose: hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
// Latency: purely combinational. Backpressure: none.
// Ports: hex_i (4-bit value), seg_o (7-bit active-low segments).
module hex_to_seg7
  import keypad_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    unique case (hex_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/keypad_entry_display.sv
// Purpose: debounce keypad decoder output into press events, shift digits into
//   a 4-digit entry buffer, and multiplex the buffer onto a 4-digit 7-seg display.
// Latency: key_strobe DEBOUNCE_CYCLES cycles after first valid sample; an/seg one cycle after digit select.
// Backpressure: none; inputs are sampled every cycle.
// Ports: clk, rst_n (async active-low); key_code/key_valid from decoder; clear
//   (sync buffer clear); key_strobe (press pulse); digits (buffer, [3:0] newest);
//   an (active-low anodes, an[0] rightmost); seg (active-low {g..a}).
module keypad_entry_display
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int REFRESH_CYCLES  = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  key_code,
  input  logic        key_valid,
  input  logic        clear,
  output logic        key_strobe,
  output logic [15:0] digits,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int RW = $clog2(REFRESH_CYCLES);
  localparam logic [DW-1:0] DB_ONE  = DW'(1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RF_ONE  = RW'(1);
  localparam logic [RW-1:0] RF_LAST = RW'(REFRESH_CYCLES - 1);

  kp_state_e      st_q, st_d;
  logic [3:0]     cand_q, cand_d;
  logic [DW-1:0]  cnt_q, cnt_d;
  logic           strobe_q, strobe_d;
  logic [15:0]    digits_q, digits_d;
  logic [2:0]     count_q, count_d;
  logic [RW-1:0]  ref_q, ref_d;
  logic [1:0]     sel_q, sel_d;
  logic [3:0]     an_q, an_d;
  logic [6:0]     seg_q, seg_d;

  logic           accept;
  logic           enabled;
  logic [3:0]     sel_nib;
  logic [6:0]     sel_pat;

  // Debounce FSM. cnt counts consecutive matching samples, so a press is
  // accepted on the DEBOUNCE_CYCLES-th stable sample.
  always_comb begin
    st_d   = st_q;
    cand_d = cand_q;
    cnt_d  = cnt_q;
    accept = 1'b0;
    unique case (st_q)
      ST_IDLE: begin
        if (key_valid) begin
          cand_d = key_code;
          cnt_d  = DB_ONE;
          st_d   = ST_PRESS_WAIT;
        end
      end
      ST_PRESS_WAIT: begin
        if (!key_valid) begin
          st_d = ST_IDLE;
        end else if (key_code != cand_q) begin
          cand_d = key_code;
          cnt_d  = DB_ONE;
        end else if (cnt_q == DB_LAST) begin
          st_d   = ST_HELD;
          accept = 1'b1;
        end else begin
          cnt_d = cnt_q + DB_ONE;
        end
      end
      ST_HELD: begin
        if (!key_valid) begin
          cnt_d = DB_ONE;
          st_d  = ST_RELEASE_WAIT;
        end
      end
      ST_RELEASE_WAIT: begin
        // A bounce back to valid resumes the hold without a new event.
        if (key_valid) begin
          st_d = ST_HELD;
        end else if (cnt_q == DB_LAST) begin
          st_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + DB_ONE;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  // Entry buffer; clear takes priority over a shift landing on the same edge.
  always_comb begin
    strobe_d = accept;
    digits_d = digits_q;
    count_d  = count_q;
    if (clear) begin
      digits_d = 16'h0000;
      count_d  = 3'd0;
    end else if (accept) begin
      digits_d = {digits_q[11:0], cand_q};
      if (count_q != 3'd4) count_d = count_q + 3'd1;
    end
  end

  // Display refresh: select advances once per REFRESH_CYCLES, 2-bit wrap.
  always_comb begin
    ref_d = ref_q + RF_ONE;
    sel_d = sel_q;
    if (ref_q == RF_LAST) begin
      ref_d = '0;
      sel_d = sel_q + 2'd1;
    end
  end

  // Only digits that have actually been entered are lit.
  assign enabled = ({1'b0, sel_q} < count_q);
  assign sel_nib = digits_q[{sel_q, 2'b00} +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .hex_i (sel_nib),
    .seg_o (sel_pat)
  );

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    if (enabled) begin
      an_d  = ~(4'b0001 << sel_q);
      seg_d = sel_pat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= ST_IDLE;
      cand_q   <= 4'h0;
      cnt_q    <= '0;
      strobe_q <= 1'b0;
      digits_q <= 16'h0000;
      count_q  <= 3'd0;
      ref_q    <= '0;
      sel_q    <= 2'd0;
      an_q     <= AN_OFF;
      seg_q    <= SEG_BLANK;
    end else begin
      st_q     <= st_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
      digits_q <= digits_d;
      count_q  <= count_d;
      ref_q    <= ref_d;
      sel_q    <= sel_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign key_strobe = strobe_q;
  assign digits     = digits_q;
  assign an         = an_q;
  assign seg        = seg_q;

endmodule

// File: tb/tb_keypad_entry_display.sv
// Directed bench for keypad_entry_display with DEBOUNCE_CYCLES=4, REFRESH_CYCLES=8.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_keypad_entry_display;

  localparam int DB = 4;
  localparam int RF = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        clear;
  logic        key_strobe;
  logic [15:0] digits;
  logic [3:0]  an;
  logic [6:0]  seg;

  int checks   = 0;
  int failures = 0;

  keypad_entry_display #(
    .DEBOUNCE_CYCLES (DB),
    .REFRESH_CYCLES  (RF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .clear      (clear),
    .key_strobe (key_strobe),
    .digits     (digits),
    .an         (an),
    .seg        (seg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run n cycles, counting strobes and the 1-based cycle of the first one.
  task automatic run_count(input int n, output int strobes, output int first);
    strobes = 0;
    first   = -1;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (key_strobe === 1'b1) begin
        strobes++;
        if (first < 0) first = i;
      end
    end
  endtask

  task automatic press_key(input logic [3:0] code);
    int s, f;
    key_code  = code;
    key_valid = 1'b1;
    run_count(6, s, f);
    key_valid = 1'b0;
    run_count(6, s, f);
  endtask

  task automatic wait_an(input logic [3:0] target, output int found);
    found = 0;
    for (int i = 0; i < 64 && found == 0; i++) begin
      tick();
      if (an === target) found = 1;
    end
  endtask

  initial begin
    int s, f, s2, f2, bad, seen, badseg, found;
    logic [3:0] an_seq [4];
    logic [6:0] seg_seq [4];

    rst_n     = 1'b0;
    key_code  = 4'h0;
    key_valid = 1'b0;
    clear     = 1'b0;

    // Reset state
    #12;
    chk("rst_an",     16'(an),         16'h000F);
    chk("rst_seg",    16'(seg),        16'h007F);
    chk("rst_digits", digits,          16'h0000);
    chk("rst_strobe", 16'(key_strobe), 16'h0000);
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (an !== 4'hF) bad++;
    end
    chk("idle_an_off", 16'(bad), 16'd0);

    // Clean press of key 1
    key_code  = 4'h1;
    key_valid = 1'b1;
    run_count(20, s, f);
    chk("clean_strobes", 16'(s), 16'd1);
    chk("clean_latency", 16'(f), 16'd4);
    key_valid = 1'b0;
    run_count(10, s, f);
    chk("clean_release_nostrobe", 16'(s), 16'd0);
    chk("clean_digits", digits, 16'h0001);
    seen = 0; badseg = 0; bad = 0;
    for (int i = 0; i < 4 * RF * 3; i++) begin
      tick();
      if (an === 4'b1110) begin
        seen++;
        if (seg !== 7'b1111001) badseg++;
      end else if (an !== 4'b1111) begin
        bad++;
      end
    end
    chk("clean_an0_lit_cycles", 16'(seen),   16'd24);
    chk("clean_seg_pattern",    16'(badseg), 16'd0);
    chk("clean_an_hi_off",      16'(bad),    16'd0);

    // Bounce on press, then stable A
    key_code = 4'hA;
    s = 0;
    key_valid = 1'b1; run_count(1, s2, f2); s += s2;
    key_valid = 1'b0; run_count(1, s2, f2); s += s2;
    key_valid = 1'b1; run_count(1, s2, f2); s += s2;
    key_valid = 1'b1; run_count(1, s2, f2); s += s2;
    key_valid = 1'b0; run_count(1, s2, f2); s += s2;
    chk("bounce_no_early_strobe", 16'(s), 16'd0);
    key_valid = 1'b1;
    run_count(20, s, f);
    chk("bounce_strobes", 16'(s), 16'd1);
    chk("bounce_latency", 16'(f), 16'd4);
    chk("bounce_digits",  digits, 16'h001A);
    // Release glitch: 2 cycles low, back high
    key_valid = 1'b0; run_count(2, s, f);
    key_valid = 1'b1; run_count(10, s2, f2);
    chk("glitch_no_strobe", 16'(s + s2), 16'd0);
    key_valid = 1'b0; run_count(10, s, f);
    chk("bounce_release_nostrobe", 16'(s), 16'd0);

    // Fill and overflow
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clear_digits", digits, 16'h0000);
    press_key(4'h1);
    press_key(4'h2);
    press_key(4'h3);
    press_key(4'hA);
    press_key(4'h4);
    chk("fill_digits", digits, 16'h23A4);
    an_seq[0] = 4'b1110; seg_seq[0] = 7'b0011001;
    an_seq[1] = 4'b1101; seg_seq[1] = 7'b0001000;
    an_seq[2] = 4'b1011; seg_seq[2] = 7'b0110000;
    an_seq[3] = 4'b0111; seg_seq[3] = 7'b0100100;
    for (int k = 0; k < 4; k++) begin
      wait_an(an_seq[k], found);
      chk($sformatf("fill_an_seen_%0d", k), 16'(found), 16'd1);
      chk($sformatf("fill_seg_%0d", k), 16'(seg), 16'(seg_seq[k]));
    end

    // Clear on the same edge the press is accepted
    key_code  = 4'h7;
    key_valid = 1'b1;
    run_count(3, s, f);
    chk("collide_no_early_strobe", 16'(s), 16'd0);
    clear = 1'b1;
    tick();
    chk("collide_strobe", 16'(key_strobe), 16'd1);
    chk("collide_digits", digits, 16'h0000);
    clear     = 1'b0;
    key_valid = 1'b0;
    run_count(10, s, f);
    bad = 0;
    for (int i = 0; i < 4 * RF; i++) begin
      tick();
      if (an !== 4'b1111) bad++;
    end
    chk("collide_an_off", 16'(bad), 16'd0);

    // Reset while a key is held
    key_code  = 4'h5;
    key_valid = 1'b1;
    run_count(8, s, f);
    chk("hold_strobes", 16'(s), 16'd1);
    chk("hold_digits",  digits, 16'h0005);
    rst_n = 1'b0;
    #1;
    chk("midrst_digits", digits,          16'h0000);
    chk("midrst_an",     16'(an),         16'h000F);
    chk("midrst_seg",    16'(seg),        16'h007F);
    chk("midrst_strobe", 16'(key_strobe), 16'h0000);
    tick();
    rst_n = 1'b1;
    run_count(20, s, f);
    chk("postrst_strobes", 16'(s), 16'd1);
    chk("postrst_latency", 16'(f), 16'd4);
    chk("postrst_digits",  digits, 16'h0005);
    key_valid = 1'b0;
    run_count(10, s, f);
    chk("postrst_release_nostrobe", 16'(s), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
